// File: rtl/huffman_pkg.sv
// Shared types and helpers for the Huffman receive path.
// Holds the symbol count, code width, decoder state encoding and the
// mask-to-length popcount used when the code table is captured.
package huffman_pkg;

    localparam int NUM_SYM = 6;
    localparam int CODE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Number of ones in a mask; the masks are contiguous low-order ones, so
    // this is the codeword length in bits (0 means the symbol is absent).
    function automatic logic [3:0] popcount(input logic [CODE_W-1:0] i_mask);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < CODE_W; i++) begin
            cnt = cnt + {3'd0, i_mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Per-symbol codeword comparator.
// Hits when the post-shift bit count equals this symbol's code length and the
// masked post-shift shift register equals the stored codeword. An absent
// symbol (length 0) never hits.
module huffman_code_match
    import huffman_pkg::*;
#(
    parameter int SR_W  = 8,
    parameter int LEN_W = 4
) (
    input  logic [SR_W-1:0]   i_sr_next,
    input  logic [LEN_W-1:0]  i_len_next,
    input  logic [CODE_W-1:0] i_code,
    input  logic [CODE_W-1:0] i_mask,
    input  logic [LEN_W-1:0]  i_code_len,
    output logic              o_hit
);

    logic [SR_W-1:0] w_code_ext;
    logic [SR_W-1:0] w_mask_ext;

    assign w_code_ext = SR_W'(i_code);
    assign w_mask_ext = SR_W'(i_mask);

    // Length must line up exactly; the mask selects the low bits just shifted in.
    always_comb begin
        o_hit = 1'b0;
        if ((i_code_len != {LEN_W{1'b0}}) && (i_len_next == i_code_len) &&
            ((i_sr_next & w_mask_ext) == w_code_ext)) begin
            o_hit = 1'b1;
        end else begin
            o_hit = 1'b0;
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for the 6-symbol gray-level encoder.
// Captures HC/M on code_valid, shifts bits in one per cycle, and presents the
// decoded symbol (1..6) on a valid/ready handshake. Sticky err when no
// codeword matches within MAX_LEN bits.
// Optional build macro HUFFMAN_DEC_CNT_EN adds per-symbol decoded counters
// DCNT1..DCNT6 (8-bit, wrapping).
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int SYM_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_data,
    input  logic              sym_ready,
    output logic              err
`ifdef HUFFMAN_DEC_CNT_EN
    ,
    output logic [7:0]        DCNT1,
    output logic [7:0]        DCNT2,
    output logic [7:0]        DCNT3,
    output logic [7:0]        DCNT4,
    output logic [7:0]        DCNT5,
    output logic [7:0]        DCNT6
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [MAX_LEN-1:0] r_sr;
    logic [MAX_LEN-1:0] w_sr_shift;
    logic [MAX_LEN-1:0] w_sr_d;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   w_len_inc;
    logic [LEN_W-1:0]   w_len_d;

    logic               r_sym_valid;
    logic               w_sym_valid_d;
    logic [SYM_W-1:0]   r_sym_data;
    logic [SYM_W-1:0]   w_sym_data_d;
    logic               r_err;
    logic               w_err_d;

    logic [CODE_W-1:0]  r_hc       [NUM_SYM];
    logic [CODE_W-1:0]  r_mask     [NUM_SYM];
    logic [LEN_W-1:0]   r_code_len [NUM_SYM];
    logic [CODE_W-1:0]  w_hc_in    [NUM_SYM];
    logic [CODE_W-1:0]  w_mask_in  [NUM_SYM];

    logic [NUM_SYM-1:0] w_hit;
    logic               w_any_hit;
    logic [SYM_W-1:0]   w_hit_sym;
    logic               w_bit_ready;
    logic               w_accept;

    assign w_hc_in[0]   = HC1;
    assign w_hc_in[1]   = HC2;
    assign w_hc_in[2]   = HC3;
    assign w_hc_in[3]   = HC4;
    assign w_hc_in[4]   = HC5;
    assign w_hc_in[5]   = HC6;
    assign w_mask_in[0] = M1;
    assign w_mask_in[1] = M2;
    assign w_mask_in[2] = M3;
    assign w_mask_in[3] = M4;
    assign w_mask_in[4] = M5;
    assign w_mask_in[5] = M6;

    // Bits are only taken in RUN and never while a symbol is waiting downstream.
    assign w_bit_ready = (r_state == RUN) && !r_sym_valid;
    assign w_accept    = bit_valid && w_bit_ready;
    assign w_sr_shift  = {r_sr[MAX_LEN-2:0], bit_in};
    assign w_len_inc   = r_len + LEN_W'(1);

    assign bit_ready = w_bit_ready;
    assign sym_valid = r_sym_valid;
    assign sym_data  = r_sym_data;
    assign err       = r_err;

    for (genvar g = 0; g < NUM_SYM; g++) begin : g_match
        huffman_code_match #(
            .SR_W  (MAX_LEN),
            .LEN_W (LEN_W)
        ) u_match (
            .i_sr_next  (w_sr_shift),
            .i_len_next (w_len_inc),
            .i_code     (r_hc[g]),
            .i_mask     (r_mask[g]),
            .i_code_len (r_code_len[g]),
            .o_hit      (w_hit[g])
        );
    end

    assign w_any_hit = |w_hit;

    // Priority encoder: with a malformed table the lowest symbol index wins.
    always_comb begin
        w_hit_sym = {SYM_W{1'b0}};
        casez (w_hit)
            6'b?????1: w_hit_sym = SYM_W'(3'd1);
            6'b????10: w_hit_sym = SYM_W'(3'd2);
            6'b???100: w_hit_sym = SYM_W'(3'd3);
            6'b??1000: w_hit_sym = SYM_W'(3'd4);
            6'b?10000: w_hit_sym = SYM_W'(3'd5);
            6'b100000: w_hit_sym = SYM_W'(3'd6);
            default:   w_hit_sym = {SYM_W{1'b0}};
        endcase
    end

    // Next-state and next-datapath logic; code_valid overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_sr_d        = r_sr;
        w_len_d       = r_len;
        w_sym_valid_d = r_sym_valid;
        w_sym_data_d  = r_sym_data;
        w_err_d       = r_err;
        if (code_valid) begin
            w_state_next  = RUN;
            w_sr_d        = {MAX_LEN{1'b0}};
            w_len_d       = {LEN_W{1'b0}};
            w_sym_valid_d = 1'b0;
            w_err_d       = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = IDLE;
                end
                RUN: begin
                    if (r_sym_valid) begin
                        if (sym_ready) begin
                            w_sym_valid_d = 1'b0;
                        end else begin
                            w_sym_valid_d = 1'b1;
                        end
                    end else if (w_accept) begin
                        if (w_any_hit) begin
                            w_sym_valid_d = 1'b1;
                            w_sym_data_d  = w_hit_sym;
                            w_sr_d        = {MAX_LEN{1'b0}};
                            w_len_d       = {LEN_W{1'b0}};
                        end else if (w_len_inc == LEN_W'(MAX_LEN)) begin
                            // Longest legal codeword reached without a match.
                            w_state_next = ERR;
                            w_err_d      = 1'b1;
                            w_sr_d       = {MAX_LEN{1'b0}};
                            w_len_d      = {LEN_W{1'b0}};
                        end else begin
                            w_sr_d  = w_sr_shift;
                            w_len_d = w_len_inc;
                        end
                    end else begin
                        w_state_next = RUN;
                    end
                end
                ERR: begin
                    w_state_next = ERR;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift register, length counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr        <= {MAX_LEN{1'b0}};
            r_len       <= {LEN_W{1'b0}};
            r_sym_valid <= 1'b0;
            r_sym_data  <= {SYM_W{1'b0}};
            r_err       <= 1'b0;
        end else begin
            r_sr        <= w_sr_d;
            r_len       <= w_len_d;
            r_sym_valid <= w_sym_valid_d;
            r_sym_data  <= w_sym_data_d;
            r_err       <= w_err_d;
        end
    end

    // Code table capture; lengths are precomputed so the match path stays short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                r_hc[i]       <= {CODE_W{1'b0}};
                r_mask[i]     <= {CODE_W{1'b0}};
                r_code_len[i] <= {LEN_W{1'b0}};
            end
        end else if (code_valid) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                r_hc[i]       <= w_hc_in[i];
                r_mask[i]     <= w_mask_in[i];
                r_code_len[i] <= LEN_W'(popcount(w_mask_in[i]));
            end
        end
    end

`ifdef HUFFMAN_DEC_CNT_EN
    logic [7:0] r_dcnt [NUM_SYM];

    // Per-symbol delivered counts, bumped on each completed handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                r_dcnt[i] <= 8'd0;
            end
        end else if (code_valid) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                r_dcnt[i] <= 8'd0;
            end
        end else if (r_sym_valid && sym_ready) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                if (r_sym_data == SYM_W'(i + 1)) begin
                    r_dcnt[i] <= r_dcnt[i] + 8'd1;
                end
            end
        end
    end

    assign DCNT1 = r_dcnt[0];
    assign DCNT2 = r_dcnt[1];
    assign DCNT3 = r_dcnt[2];
    assign DCNT4 = r_dcnt[3];
    assign DCNT5 = r_dcnt[4];
    assign DCNT6 = r_dcnt[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed scenarios plus a
// randomized symbol stream checked against a symbol-level reference model.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       code_valid;
    logic [7:0] hc_s [6];
    logic [7:0] m_s  [6];
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       sym_ready;
    logic       err;
`ifdef HUFFMAN_DEC_CNT_EN
    logic [7:0] dcnt [6];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mdl_code [6];
    int mdl_len  [6];

    always #5 clk = ~clk;

    huffman_decoder #(.MAX_LEN(8), .SYM_W(8)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .code_valid (code_valid),
        .HC1        (hc_s[0]),
        .HC2        (hc_s[1]),
        .HC3        (hc_s[2]),
        .HC4        (hc_s[3]),
        .HC5        (hc_s[4]),
        .HC6        (hc_s[5]),
        .M1         (m_s[0]),
        .M2         (m_s[1]),
        .M3         (m_s[2]),
        .M4         (m_s[3]),
        .M5         (m_s[4]),
        .M6         (m_s[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .err        (err)
`ifdef HUFFMAN_DEC_CNT_EN
        ,
        .DCNT1      (dcnt[0]),
        .DCNT2      (dcnt[1]),
        .DCNT3      (dcnt[2]),
        .DCNT4      (dcnt[3]),
        .DCNT5      (dcnt[4]),
        .DCNT6      (dcnt[5])
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: unary table, 1: unary without symbol 6, 2: fixed 3-bit, 3: overlapping 2/3
    task automatic load_table(input int id);
        for (int i = 0; i < 6; i++) begin
            if (id <= 1) begin
                if (i < 5) begin
                    hc_s[i] = 8'((1 << (i + 1)) - 2);
                    m_s[i]  = 8'((1 << (i + 1)) - 1);
                end else begin
                    hc_s[i] = 8'd31;
                    m_s[i]  = (id == 1) ? 8'd0 : 8'd31;
                end
            end else if (id == 2) begin
                hc_s[i] = 8'(i);
                m_s[i]  = 8'd7;
            end else begin
                hc_s[i] = (i == 1 || i == 2) ? 8'd1 : 8'd0;
                m_s[i]  = (i == 1 || i == 2) ? 8'd1 : 8'd0;
            end
            mdl_code[i] = int'(hc_s[i] & m_s[i]);
            mdl_len[i]  = $countones(m_s[i]);
        end
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int w = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        while (bit_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (w >= 20) begin
            n_errors++;
            $display("FAIL bit_accept_timeout: bit_ready=%b after %0d cycles, required 1", bit_ready, w);
        end
        tick();
        bit_valid = 1'b0;
    endtask

    // Sends the codeword of symbol s and checks the 1-cycle decode latency.
    task automatic send_sym_check(input int s);
        int l = mdl_len[s-1];
        for (int j = 0; j < l; j++) begin
            send_bit(1'((mdl_code[s-1] >> (l - 1 - j)) & 1));
            if (j < l - 1) begin
                n_checks++;
                if (sym_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL early_sym_valid: sym %0d bit %0d sym_valid=%b required 0", s, j, sym_valid);
                end
            end
        end
        n_checks++;
        if (sym_valid !== 1'b1 || sym_data !== 8'(s)) begin
            n_errors++;
            $display("FAIL decode_sym: sym_valid=%b sym_data=%0d required 1/%0d", sym_valid, sym_data, s);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin hc_s[i] = 8'd0; m_s[i] = 8'd0; end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bit_ready !== 1'b0 || sym_valid !== 1'b0 || sym_data !== 8'd0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: rdy=%b sv=%b sd=%0d err=%b required 0/0/0/0", bit_ready, sym_valid, sym_data, err);
        end
        bit_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_ignores_bits: rdy=%b sv=%b required 0/0", bit_ready, sym_valid);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_basic();
        int seq [4] = '{1, 2, 3, 6};
        load_table(0);
        sym_ready = 1'b1;
        n_checks++;
        if (bit_ready !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL run_after_table: rdy=%b err=%b required 1/0", bit_ready, err);
        end
        foreach (seq[k]) send_sym_check(seq[k]);
        tick();
        n_checks++;
        if (sym_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL handshake_drop: sym_valid=%b required 0", sym_valid);
        end
    endtask

    task automatic test_stall();
        load_table(0);
        sym_ready = 1'b0;
        send_sym_check(1);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (sym_valid !== 1'b1 || sym_data !== 8'd1 || bit_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold: sv=%b sd=%0d rdy=%b required 1/1/0", sym_valid, sym_data, bit_ready);
            end
        end
        sym_ready = 1'b1;
        tick();
        n_checks++;
        if (sym_valid !== 1'b0 || bit_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: sv=%b rdy=%b required 0/1", sym_valid, bit_ready);
        end
        send_sym_check(2);
    endtask

    task automatic test_partial();
        load_table(0);
        sym_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        load_table(0);
        send_sym_check(1);
    endtask

    task automatic test_priority();
        load_table(3);
        sym_ready = 1'b1;
        send_bit(1'b1);
        n_checks++;
        if (sym_valid !== 1'b1 || sym_data !== 8'd2) begin
            n_errors++;
            $display("FAIL priority_lowest: sv=%b sd=%0d required 1/2", sym_valid, sym_data);
        end
    endtask

    task automatic test_error();
        load_table(1);
        sym_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_bit(1'b1);
            n_checks++;
            if (k < 7) begin
                if (err !== 1'b0 || bit_ready !== 1'b1 || sym_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL err_early: bit %0d err=%b rdy=%b sv=%b required 0/1/0", k, err, bit_ready, sym_valid);
                end
            end else begin
                if (err !== 1'b1 || bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL err_set: err=%b rdy=%b sv=%b required 1/0/0", err, bit_ready, sym_valid);
                end
            end
        end
        bit_valid = 1'b1;
        repeat (3) tick();
        bit_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || bit_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL err_sticky: err=%b rdy=%b required 1/0", err, bit_ready);
        end
        load_table(0);
        n_checks++;
        if (err !== 1'b0 || bit_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL err_clear: err=%b rdy=%b required 0/1", err, bit_ready);
        end
        send_sym_check(1);
    endtask

    task automatic test_async_reset();
        load_table(0);
        sym_ready = 1'b0;
        send_sym_check(2);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (sym_valid !== 1'b0 || sym_data !== 8'd0 || err !== 1'b0 || bit_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: sv=%b sd=%0d err=%b rdy=%b required 0/0/0/0", sym_valid, sym_data, err, bit_ready);
        end
        repeat (2) tick();
        #2;
        reset_n = 1'b1;
        tick();
        bit_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset_idle: rdy=%b sv=%b required 0/0", bit_ready, sym_valid);
            end
        end
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        load_table(0);
        send_sym_check(1);
    endtask

    // Random symbols, random bit gaps and downstream stalls. The model knows
    // where each codeword ends from the encoding, so it predicts sym_valid,
    // sym_data and bit_ready every cycle.
    task automatic run_stream(input int nsym, input bit stall_en);
        logic bitq  [$];
        int   lastq [$];
        int   cyc = 0;
        int   dut_got = 0;
        logic exp_sv = 1'b0;
        logic [7:0] exp_data = 8'd0;
        logic bv;
        logic rdy;
        for (int k = 0; k < nsym; k++) begin
            int s = int'($urandom_range(1, 6));
            for (int j = 0; j < mdl_len[s-1]; j++) begin
                bitq.push_back(1'((mdl_code[s-1] >> (mdl_len[s-1] - 1 - j)) & 1));
                lastq.push_back((j == mdl_len[s-1] - 1) ? s : 0);
            end
        end
        while (cyc < 3000 && dut_got < nsym) begin
            n_checks++;
            if (bit_ready !== !exp_sv || sym_valid !== exp_sv || err !== 1'b0 ||
                (exp_sv && sym_data !== exp_data)) begin
                n_errors++;
                $display("FAIL stream_cycle %0d: rdy=%b sv=%b sd=%0d err=%b required %b/%b/%0d/0",
                         cyc, bit_ready, sym_valid, sym_data, err, !exp_sv, exp_sv, exp_data);
            end
            bv  = (bitq.size() > 0) && ($urandom_range(0, 3) != 0);
            rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            bit_valid = bv;
            bit_in    = bv ? bitq[0] : 1'b0;
            sym_ready = rdy;
            if (sym_valid === 1'b1 && rdy) dut_got++;
            if (exp_sv) begin
                if (rdy) exp_sv = 1'b0;
            end else if (bv) begin
                int s;
                void'(bitq.pop_front());
                s = lastq.pop_front();
                if (s != 0) begin
                    exp_sv   = 1'b1;
                    exp_data = 8'(s);
                end
            end
            tick();
            cyc++;
        end
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        n_checks++;
        if (dut_got != nsym) begin
            n_errors++;
            $display("FAIL stream_count: delivered %0d symbols, required %0d", dut_got, nsym);
        end
    endtask

    task automatic test_random();
        load_table(0);
        run_stream(40, 1'b1);
        load_table(2);
        run_stream(40, 1'b1);
        load_table(0);
        run_stream(20, 1'b0);
    endtask

    task automatic test_counts();
`ifdef HUFFMAN_DEC_CNT_EN
        int seq [4] = '{1, 1, 2, 6};
        int exp_cnt [6] = '{2, 1, 0, 0, 0, 1};
        load_table(0);
        sym_ready = 1'b1;
        foreach (seq[k]) send_sym_check(seq[k]);
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (dcnt[i] !== 8'(exp_cnt[i])) begin
                n_errors++;
                $display("FAIL dcnt%0d: got %0d required %0d", i + 1, dcnt[i], exp_cnt[i]);
            end
        end
        load_table(0);
        n_checks++;
        if (dcnt[0] !== 8'd0 || dcnt[5] !== 8'd0) begin
            n_errors++;
            $display("FAIL dcnt_clear: dcnt1=%0d dcnt6=%0d required 0/0", dcnt[0], dcnt[5]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_partial();
        test_priority();
        test_error();
        test_random();
        test_counts();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
